cache_line_read_buffer: RTL and testbench
=========================================

Name: cache_line_read_buffer

Overview:
- One-entry line buffer on the CPU read path between the datapath and the cache data array.
- On a CPU read it returns the addressed 16-bit word from a buffered 128-bit line.
- On a buffer miss it fetches the whole line from the cache with a req/resp handshake, then answers the CPU.
- It is the read-side counterpart of the byte-merge write path. CPU writes to the buffered line invalidate the buffer.

Parameters:
- LINE_WORDS, 8, 16-bit words per line; fixes offset field mem_address[3:1].
- TAG_LSB, 4, lowest address bit of the line tag (log2 of line bytes).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request; held high until mem_resp.
- mem_write  in  1  CPU write strobe; snooped for invalidation only.
- mem_address  in  16  CPU byte address (lc3b_word).
- mem_byte_enable  in  2  byte-lane mask for the read (lc3b_mem_wmask).
- mem_rdata  out  16  returned word, masked per byte lanes.
- mem_resp  out  1  one-cycle pulse; mem_rdata is valid in this cycle.
- line_read  out  1  line fetch request to the cache; held until line_resp.
- line_address  out  16  {mem_address[15:4], 4'b0}, stable while line_read is high.
- line_resp  in  1  one-cycle pulse; line_rdata is valid in this cycle.
- line_rdata  in  128  fetched line (lc3b_cache_line); word k is in bits [16k+15:16k].
- flush  in  1  invalidate the buffer.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, buf_valid=0, buf_tag=0, buf_line=0, flush_pend=0.
  - mem_resp=0, mem_rdata=16'h0000, line_read=0, line_address=16'h0000.
  - line_read drops immediately, even mid-FETCH; a later line_resp is ignored in IDLE.
- States: IDLE, FETCH, RESPOND.
- IDLE:
  - mem_read && buf_valid && buf_tag==mem_address[15:4] (hit): latch word/lane data into the mem_rdata register, go to RESPOND. Latency is 1 cycle from request to mem_resp.
  - mem_read otherwise (miss): go to FETCH. line_read and line_address are registered, so they appear from the next cycle.
- FETCH:
  - line_read=1.
  - On line_resp: buf_line<=line_rdata, buf_tag<=addr[15:4], buf_valid<=~(flush|flush_pend), flush_pend<=0. The word is selected directly from line_rdata; go to RESPOND.
  - Miss latency = 2 + line wait cycles.
- RESPOND:
  - mem_resp=1 for exactly one cycle, then IDLE.
  - The CPU deasserts mem_read in the cycle after mem_resp, so IDLE never re-services the same request.
- Word select: word index = mem_address[3:1]; mem_address[0] is ignored (the CPU does the byte shift).
- Lane mask:
  - mem_rdata[7:0] is zeroed unless byte_enable[0]=1; mem_rdata[15:8] is zeroed unless byte_enable[1]=1.
  - byte_enable=2'b00 returns 16'h0000 with a normal resp.
- mem_rdata holds its last value outside RESPOND.
- Invalidation:
  - mem_write with mem_address[15:4]==buf_tag clears buf_valid at that edge, in any state.
  - flush clears buf_valid in any state.
  - flush or a matching write during FETCH sets flush_pend. The in-flight line is still returned to the CPU but is not kept valid.
- Simultaneous events:
  - flush in the same cycle as an IDLE hit: the hit is still served from the current data, and valid clears at that edge.
  - mem_read and mem_write both high is illegal; behaviour is unspecified but must not hang.
- mem_read dropped during FETCH (protocol violation): the fetch completes, the buffer fills, and the resp pulse is still issued.
- Wrap/edges: address 16'hFFFE selects word 7 of tag 12'hFFF. No carry into the tag.

Decomposition:
- lc3b_types (shared) holds the existing lc3b_word, lc3b_cache_line and lc3b_mem_wmask types. Add lc3b_line_tag (12 bits) and enum lc3b_rbuf_state {IDLE, FETCH, RESPOND}.
- Sub-module line_word_select (combinational): 128-bit line + 3-bit index + 2-bit mask -> 16-bit word. It is reused by the hit path and the fill path.

Test Plan:
- Cold read: after reset, mem_read at 16'h1236, cache answers line_resp 3 cycles after line_read with line word k = 16'hA0A0+k. Required: line_address=16'h1230, mem_rdata=16'hA0A3, mem_resp 1 cycle wide.
- Hit: next mem_read at 16'h123E, byte_enable 2'b11. Required: no line_read, mem_resp 1 cycle after the request, mem_rdata=16'hA0A7.
- Byte mask: read 16'h1232 with byte_enable 2'b01 -> 16'h00A1; with 2'b10 -> 16'hA000.
- Snoop: mem_write to 16'h1234, then mem_read 16'h1234. Required: refetch with line_read and line_address=16'h1230. A write to 16'h5678 must not invalidate.
- Flush during FETCH: flush pulse while line_read is high. Required: the CPU gets the correct word, and an immediate re-read of the same address issues a new line_read.
- Reset mid-FETCH: drop reset_n while line_read=1. Required: line_read=0 asynchronously, outputs at reset values, a stray line_resp is ignored, the next read performs a fresh fetch.

Source files
------------

// File: rtl/cache_line_read_buffer_pkg.sv
// Shared LC-3b types and sizing for the one-entry CPU read line buffer.
package cache_line_read_buffer_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;
    localparam int unsigned TAG_LSB    = 4;
    localparam int unsigned TAG_W      = ADDR_W - TAG_LSB;
    localparam int unsigned OFS_W      = TAG_LSB - 1;
    localparam int unsigned MASK_W     = 2;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_cache_line;
    typedef logic [MASK_W-1:0] lc3b_mem_wmask;
    typedef logic [TAG_W-1:0]  lc3b_line_tag;
    typedef logic [OFS_W-1:0]  lc3b_word_idx;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESPOND = 2'd2
    } lc3b_rbuf_state;

    // CPU request captured at miss time so the fill does not depend on the CPU holding it.
    typedef struct packed {
        lc3b_line_tag  tag;
        lc3b_word_idx  idx;
        lc3b_mem_wmask mask;
    } lc3b_rbuf_req;

endpackage

// File: rtl/line_word_select.sv
// Picks one 16-bit word out of a cache line and zeroes disabled byte lanes.
module line_word_select
    import cache_line_read_buffer_pkg::*;
(
    input  lc3b_cache_line line_i,
    input  lc3b_word_idx   idx_i,
    input  lc3b_mem_wmask  mask_i,
    output lc3b_word       word_o
);

    lc3b_word sel;

    // Word mux followed by per-lane masking.
    always_comb begin
        sel = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (idx_i == OFS_W'(k)) begin
                sel = line_i[k*WORD_W +: WORD_W];
            end
        end
        word_o = {mask_i[1] ? sel[15:8] : 8'h00,
                  mask_i[0] ? sel[7:0]  : 8'h00};
    end

endmodule

// File: rtl/cache_line_read_buffer.sv
// One-entry line buffer on the CPU read path: serves hits from a buffered
// line, fetches the whole line from the cache on a miss, and drops the line
// on flush or on a CPU write into it.
module cache_line_read_buffer
    import cache_line_read_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mem_read,
    input  logic           mem_write,
    input  lc3b_word       mem_address,
    input  lc3b_mem_wmask  mem_byte_enable,
    output lc3b_word       mem_rdata,
    output logic           mem_resp,
    output logic           line_read,
    output lc3b_word       line_address,
    input  logic           line_resp,
    input  lc3b_cache_line line_rdata,
    input  logic           flush
);

    lc3b_rbuf_state state_q, state_d;
    logic           buf_valid_q, buf_valid_d;
    lc3b_line_tag   buf_tag_q, buf_tag_d;
    lc3b_cache_line buf_line_q, buf_line_d;
    logic           flush_pend_q, flush_pend_d;
    lc3b_rbuf_req   req_q, req_d;
    lc3b_word       mem_rdata_q, mem_rdata_d;
    logic           mem_resp_q, mem_resp_d;
    logic           line_read_q, line_read_d;
    lc3b_word       line_address_q, line_address_d;

    lc3b_line_tag   cpu_tag;
    lc3b_word_idx   cpu_idx;
    logic           hit;
    logic           snoop_buf;
    logic           snoop_fetch;
    lc3b_word       hit_word;
    lc3b_word       fill_word;
    logic           unused_addr_lsb;

    assign cpu_tag         = mem_address[ADDR_W-1:TAG_LSB];
    assign cpu_idx         = mem_address[TAG_LSB-1:1];
    // The CPU performs the byte shift itself, so the byte-address LSB is don't-care.
    assign unused_addr_lsb = mem_address[0];

    assign hit         = buf_valid_q && (buf_tag_q == cpu_tag);
    assign snoop_buf   = mem_write && (cpu_tag == buf_tag_q);
    assign snoop_fetch = mem_write && (cpu_tag == req_q.tag);

    // Hit path reads the buffered line with the live CPU request.
    line_word_select u_hit_sel (
        .line_i (buf_line_q),
        .idx_i  (cpu_idx),
        .mask_i (mem_byte_enable),
        .word_o (hit_word)
    );

    // Fill path reads the returning line with the captured request.
    line_word_select u_fill_sel (
        .line_i (line_rdata),
        .idx_i  (req_q.idx),
        .mask_i (req_q.mask),
        .word_o (fill_word)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            buf_valid_q    <= 1'b0;
            buf_tag_q      <= '0;
            buf_line_q     <= '0;
            flush_pend_q   <= 1'b0;
            req_q          <= '0;
            mem_rdata_q    <= '0;
            mem_resp_q     <= 1'b0;
            line_read_q    <= 1'b0;
            line_address_q <= '0;
        end else begin
            state_q        <= state_d;
            buf_valid_q    <= buf_valid_d;
            buf_tag_q      <= buf_tag_d;
            buf_line_q     <= buf_line_d;
            flush_pend_q   <= flush_pend_d;
            req_q          <= req_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_resp_q     <= mem_resp_d;
            line_read_q    <= line_read_d;
            line_address_q <= line_address_d;
        end
    end

    // Next-state, invalidation and registered-output logic.
    always_comb begin
        state_d        = state_q;
        buf_valid_d    = buf_valid_q;
        buf_tag_d      = buf_tag_q;
        buf_line_d     = buf_line_q;
        flush_pend_d   = flush_pend_q;
        req_d          = req_q;
        mem_rdata_d    = mem_rdata_q;
        mem_resp_d     = 1'b0;
        line_read_d    = line_read_q;
        line_address_d = line_address_q;

        // Invalidation applies in every state; a fill below overrides it with its own verdict.
        if (flush || snoop_buf) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (mem_read) begin
                    if (hit) begin
                        mem_rdata_d = hit_word;
                        mem_resp_d  = 1'b1;
                        state_d     = RESPOND;
                    end else begin
                        req_d          = '{tag: cpu_tag, idx: cpu_idx, mask: mem_byte_enable};
                        line_read_d    = 1'b1;
                        line_address_d = {cpu_tag, TAG_LSB'(0)};
                        state_d        = FETCH;
                    end
                end
            end
            FETCH: begin
                if (flush || snoop_fetch) begin
                    flush_pend_d = 1'b1;
                end
                if (line_resp) begin
                    buf_line_d   = line_rdata;
                    buf_tag_d    = req_q.tag;
                    buf_valid_d  = ~(flush | flush_pend_q | snoop_fetch);
                    flush_pend_d = 1'b0;
                    mem_rdata_d  = fill_word;
                    mem_resp_d   = 1'b1;
                    line_read_d  = 1'b0;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                line_read_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign mem_rdata    = mem_rdata_q;
    assign mem_resp     = mem_resp_q;
    assign line_read    = line_read_q;
    assign line_address = line_address_q;

endmodule

// File: tb/tb_cache_line_read_buffer.sv
// Bench for the CPU read line buffer: directed scenarios plus random traffic
// against a one-entry abstract buffer model and a fixed-content cache.
module tb_cache_line_read_buffer;

    logic         clk;
    logic         reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         line_read;
    logic [15:0]  line_address;
    logic         line_resp;
    logic [127:0] line_rdata;
    logic         flush;

    int tests = 0;
    int fails = 0;

    // Abstract buffer model: is a line held, and which one.
    bit          m_valid;
    logic [11:0] m_tag;

    cache_line_read_buffer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .line_read       (line_read),
        .line_address    (line_address),
        .line_resp       (line_resp),
        .line_rdata      (line_rdata),
        .flush           (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache contents: line 0x123 holds A0A0+k, every other line a tag-derived pattern.
    function automatic logic [127:0] line_data(input logic [11:0] tag);
        logic [127:0] l;
        logic [15:0]  w;
        l = '0;
        for (int k = 0; k < 8; k++) begin
            if (tag == 12'h123) w = 16'hA0A0 + 16'(k);
            else                w = {tag, 4'h0} ^ (16'(k) * 16'h0101) ^ 16'h6C39;
            l = l | (128'(w) << (16 * k));
        end
        return l;
    endfunction

    function automatic logic [15:0] exp_word(input logic [15:0] addr, input logic [1:0] be);
        logic [127:0] l;
        logic [15:0]  w;
        int           idx;
        l   = line_data(addr[15:4]);
        idx = int'(addr[3:1]);
        w   = 16'(l >> (16 * idx));
        if (!be[0]) w = w & 16'hFF00;
        if (!be[1]) w = w & 16'h00FF;
        return w;
    endfunction

    task automatic do_read(input logic [15:0] addr, input logic [1:0] be,
                           input int w, input bit fl, input string nm);
        bit          exp_hit, saw_lr, got;
        logic [15:0] exp_data, lr_addr;
        int          cyc, lr_cnt, lat, exp_lat;
        exp_hit  = m_valid && (m_tag == addr[15:4]);
        exp_data = exp_word(addr, be);
        exp_lat  = exp_hit ? 1 : 2 + w;
        mem_read = 1'b1; mem_address = addr; mem_byte_enable = be;
        cyc = 0; lr_cnt = 0; lat = 0; saw_lr = 0; got = 0; lr_addr = '0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            line_resp = 1'b0; flush = 1'b0;
            if (mem_resp) begin
                got = 1; lat = cyc;
            end else if (line_read) begin
                if (!saw_lr) begin
                    lr_addr = line_address;
                    if (fl) flush = 1'b1;
                end
                saw_lr = 1;
                if (lr_cnt == w) begin
                    line_resp  = 1'b1;
                    line_rdata = line_data(line_address[15:4]);
                end
                lr_cnt++;
            end
        end
        mem_read = 1'b0; line_resp = 1'b0; flush = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s resp_timeout: no mem_resp within %0d cycles", nm, cyc);
        end else begin
            tests++;
            if (lat !== exp_lat) begin
                fails++;
                $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
            end
            tests++;
            if (mem_rdata !== exp_data) begin
                fails++;
                $display("FAIL %s rdata: got %h expected %h", nm, mem_rdata, exp_data);
            end
            tests++;
            if (saw_lr !== !exp_hit) begin
                fails++;
                $display("FAIL %s line_read_seen: got %0d expected %0d", nm, saw_lr, !exp_hit);
            end
            if (!exp_hit) begin
                tests++;
                if (lr_addr !== {addr[15:4], 4'h0}) begin
                    fails++;
                    $display("FAIL %s line_address: got %h expected %h", nm, lr_addr, {addr[15:4], 4'h0});
                end
            end
        end
        @(posedge clk); #1;
        tests++;
        if (mem_resp !== 1'b0) begin
            fails++;
            $display("FAIL %s resp_width: got %b expected 0", nm, mem_resp);
        end
        tests++;
        if (mem_rdata !== exp_data) begin
            fails++;
            $display("FAIL %s rdata_hold: got %h expected %h", nm, mem_rdata, exp_data);
        end
        if (!exp_hit) begin
            m_valid = !fl;
            m_tag   = addr[15:4];
        end
    endtask

    task automatic do_write(input logic [15:0] addr);
        mem_write = 1'b1; mem_address = addr;
        @(posedge clk); #1;
        mem_write = 1'b0;
        if (addr[15:4] == m_tag) m_valid = 0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_valid = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        tests++;
        if (mem_resp !== 1'b0 || line_read !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got resp=%b line_read=%b expected 0 0", mem_resp, line_read);
        end
        tests++;
        if (mem_rdata !== 16'h0000 || line_address !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got rdata=%h laddr=%h expected 0000 0000", mem_rdata, line_address);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_valid = 0; m_tag = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_and_hit();
        do_read(16'h1236, 2'b11, 3, 0, "cold_read");
        do_read(16'h123E, 2'b11, 0, 0, "hit");
    endtask

    task automatic test_byte_mask();
        do_read(16'h1232, 2'b01, 0, 0, "mask_lo");
        do_read(16'h1232, 2'b10, 0, 0, "mask_hi");
        do_read(16'h1232, 2'b00, 0, 0, "mask_none");
    endtask

    task automatic test_snoop();
        do_write(16'h5678);
        do_read(16'h1234, 2'b11, 0, 0, "snoop_other");
        do_write(16'h1234);
        do_read(16'h1234, 2'b11, 1, 0, "snoop_refetch");
    endtask

    task automatic test_flush_fetch();
        do_flush();
        do_read(16'h1236, 2'b11, 2, 1, "flush_fetch");
        do_read(16'h1236, 2'b11, 0, 0, "flush_reread");
    endtask

    task automatic test_wrap();
        do_read(16'hFFFE, 2'b11, 1, 0, "wrap_fill");
        do_read(16'hFFFF, 2'b11, 0, 0, "wrap_lsb");
    endtask

    task automatic test_reset_mid_fetch();
        int cyc;
        m_valid = 0;
        mem_read = 1'b1; mem_address = 16'h4ABC; mem_byte_enable = 2'b11;
        cyc = 0;
        while (!line_read && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        tests++;
        if (line_read !== 1'b1) begin
            fails++;
            $display("FAIL rst_fetch_start: line_read got %b expected 1", line_read);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (line_read !== 1'b0 || mem_resp !== 1'b0) begin
            fails++;
            $display("FAIL rst_async_ctrl: got line_read=%b resp=%b expected 0 0", line_read, mem_resp);
        end
        tests++;
        if (line_address !== 16'h0000 || mem_rdata !== 16'h0000) begin
            fails++;
            $display("FAIL rst_async_data: got laddr=%h rdata=%h expected 0000 0000", line_address, mem_rdata);
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        reset_n    = 1'b1;
        line_resp  = 1'b1;
        line_rdata = line_data(12'h4AB);
        @(posedge clk); #1;
        line_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (mem_resp !== 1'b0 || line_read !== 1'b0) begin
                fails++;
                $display("FAIL rst_stray_resp: got resp=%b line_read=%b expected 0 0", mem_resp, line_read);
            end
            @(posedge clk); #1;
        end
        do_read(16'h4ABC, 2'b11, 1, 0, "rst_refetch");
    endtask

    task automatic test_random();
        logic [11:0] tags [4];
        logic [15:0] a;
        int          op;
        tags[0] = 12'h123; tags[1] = 12'h456; tags[2] = 12'hFFF; tags[3] = 12'h000;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            a  = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            if (op < 7)
                do_read(a, 2'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                        $urandom_range(0, 5) == 0, "random_read");
            else if (op < 9)
                do_write(a);
            else
                do_flush();
        end
    endtask

    initial begin
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_byte_enable = '0;
        line_resp = 1'b0; line_rdata = '0; flush = 1'b0; reset_n = 1'b0;
        m_valid = 0; m_tag = '0;
        test_reset();
        test_cold_and_hit();
        test_byte_mask();
        test_snoop();
        test_flush_fetch();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
